// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, word-length decode and
// the parity expectation used by both RX and TX.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    logic [3:0] n;
    case (wls)
      WLS_5:   n = 4'd5;
      WLS_6:   n = 4'd6;
      WLS_7:   n = 4'd7;
      WLS_8:   n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  // Stick parity forces the bit to ~eps regardless of the data.
  function automatic logic expected_parity(input logic x, input logic eps,
                                           input logic sticky);
    if (sticky) return ~eps;
    return eps ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: synchroniser plus a 3-sample majority vote around mid-bit,
// resolved on the tick where the bit counter reaches MID+1.
module uart_rx_sampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_pulse_i,
  input  logic             rx_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             rxs_o,
  output logic             vote_o,
  output logic             vote_valid_o
);

  localparam int MID = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] MID_M1 = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] MID_0  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] MID_P1 = CNT_W'(MID + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             samp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      samp_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      if (baud_pulse_i && cnt_i == MID_M1) samp_q[0] <= rxs_o;
      if (baud_pulse_i && cnt_i == MID_0)  samp_q[1] <= rxs_o;
    end
  end

  assign rxs_o        = sync_q[SYNC_STAGES-1];
  // Third sample is the live synchronised value on the MID+1 tick.
  assign vote_o       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_o) |
                        (samp_q[1] & rxs_o);
  assign vote_valid_o = baud_pulse_i && (cnt_i == MID_P1);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 5-8 data bits, 16550 parity modes, break
// detection and a one-entry holding register with valid/ready and overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       oe
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       bits_left_q, bits_left_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [1:0]       wls_q, wls_d;
  logic             pen_q, pen_d, eps_q, eps_d, stick_q, stick_d;

  logic             valid_q, valid_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             pe_q, pe_d, fe_q, fe_d, bi_q, bi_d, oe_q, oe_d;

  logic             rxs, vote, vote_valid;
  logic             frame_done, frame_pe, frame_fe, frame_bi, load;
  logic [2:0]       bit_idx;

  uart_rx_sampler #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) u_sampler (
    .clk          (clk),
    .rst          (rst),
    .baud_pulse_i (baud_pulse),
    .rx_i         (rx),
    .cnt_i        (cnt_q),
    .rxs_o        (rxs),
    .vote_o       (vote),
    .vote_valid_o (vote_valid)
  );

  assign cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  assign bit_idx = 3'(data_bits(wls_q) - bits_left_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_left_d = bits_left_q;
    shift_d     = shift_q;
    par_d       = par_q;
    wls_d       = wls_q;
    pen_d       = pen_q;
    eps_d       = eps_q;
    stick_d     = stick_q;
    frame_done  = 1'b0;
    if (baud_pulse) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            cnt_d   = CNT_W'(1);
            shift_d = '0;
            par_d   = 1'b0;
            wls_d   = wls;
            pen_d   = pen;
            eps_d   = eps;
            stick_d = sticky_parity;
          end
        end
        START: begin
          cnt_d = cnt_inc;
          if (vote_valid && vote) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d     = DATA;
            bits_left_d = data_bits(wls_q);
          end
        end
        DATA: begin
          cnt_d = cnt_inc;
          if (vote_valid) shift_d[bit_idx] = vote;
          if (cnt_q == CNT_LAST) begin
            bits_left_d = bits_left_q - 4'd1;
            if (bits_left_q == 4'd1) state_d = pen_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          cnt_d = cnt_inc;
          if (vote_valid) par_d = vote;
          if (cnt_q == CNT_LAST) state_d = STOP;
        end
        STOP: begin
          cnt_d = cnt_inc;
          // Finish at mid stop bit so the next start edge is never missed.
          if (vote_valid) begin
            frame_done = 1'b1;
            cnt_d      = '0;
            state_d    = vote ? IDLE : BRK_WAIT;
          end
        end
        BRK_WAIT: begin
          if (rxs) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign frame_pe = pen_q & (par_q != expected_parity(^shift_q, eps_q, stick_q));
  assign frame_fe = ~vote;
  assign frame_bi = (shift_q == 8'h00) & (~pen_q | ~par_q) & ~vote;
  assign load     = frame_done & (~valid_q | rx_ready);

  always_comb begin
    valid_d     = valid_q;
    hold_data_d = hold_data_q;
    pe_d        = pe_q;
    fe_d        = fe_q;
    bi_d        = bi_q;
    oe_d        = oe_q;
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
      oe_d    = 1'b0;
    end
    if (load) begin
      valid_d     = 1'b1;
      hold_data_d = shift_q;
      pe_d        = frame_pe;
      fe_d        = frame_fe;
      bi_d        = frame_bi;
    end else if (frame_done) begin
      oe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_left_q <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      wls_q       <= '0;
      pen_q       <= 1'b0;
      eps_q       <= 1'b0;
      stick_q     <= 1'b0;
      valid_q     <= 1'b0;
      hold_data_q <= '0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      bi_q        <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_left_q <= bits_left_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      wls_q       <= wls_d;
      pen_q       <= pen_d;
      eps_q       <= eps_d;
      stick_q     <= stick_d;
      valid_q     <= valid_d;
      hold_data_q <= hold_data_d;
      pe_q        <= pe_d;
      fe_q        <= fe_d;
      bi_q        <= bi_d;
      oe_q        <= oe_d;
    end
  end

  assign rx_valid = valid_q;
  assign rx_data  = hold_data_q;
  assign pe       = pe_q;
  assign fe       = fe_q;
  assign bi       = bi_q;
  assign oe       = oe_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: directed frames push expected characters,
// a negedge monitor pops and compares each newly presented character.
module tb_uart_rx_os;

  logic       clk, rst, baud_pulse, rx;
  logic [1:0] wls;
  logic       pen, eps, sticky_parity, rx_ready;
  logic       rx_valid, pe, fe, bi, oe;
  logic [7:0] rx_data;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic validPrev  = 1'b0;
  logic consumedPrev = 1'b0;

  uart_rx_os #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .rx            (rx),
    .wls           (wls),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .rx_ready      (rx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .pe            (pe),
    .fe            (fe),
    .bi            (bi),
    .oe            (oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock baud tick every fourth clock.
  initial begin
    baud_pulse = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_pulse = 1'b1;
      @(posedge clk);
      #1 baud_pulse = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [7:0] d, input logic p, input logic f,
                         input logic b);
    exp_t e;
    e.data = d;
    e.pe   = p;
    e.fe   = f;
    e.bi   = b;
    sbQ.push_back(e);
  endtask

  // Holds rx for one baud tick; rp raises rx_ready only on that tick's edge.
  task automatic tick(input logic v, input logic rp);
    rx = v;
    do begin
      @(posedge clk);
      #2;
    end while (!baud_pulse);
    if (rp) rx_ready = 1'b1;
    @(posedge clk);
    #1;
    if (rp) rx_ready = 1'b0;
  endtask

  task automatic sendBit(input logic v, input int glitchTick);
    for (int k = 0; k < 16; k++) tick(v ^ (k == glitchTick), 1'b0);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int nbits,
                               input logic parEn, input logic parBit,
                               input int glitchBit, input logic consume,
                               input logic latCheck);
    sendBit(1'b0, -1);
    for (int i = 0; i < nbits; i++) sendBit(d[i], (i == glitchBit) ? 8 : -1);
    if (parEn) sendBit(parBit, -1);
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, consume && (k == 9));
      if (latCheck && k == 8) checkOutput("lat_before", {7'b0, rx_valid}, 8'h00);
      if (latCheck && k == 9) begin
        checkOutput("lat_valid", {7'b0, rx_valid}, 8'h01);
        @(posedge clk);
        #1;
        checkOutput("one_pulse", {7'b0, rx_valid}, 8'h00);
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, {7'b0, rx_valid}, 8'h00);
    checkOutput({tag, "_data"}, rx_data, 8'h00);
    checkOutput({tag, "_pe"}, {7'b0, pe}, 8'h00);
    checkOutput({tag, "_fe"}, {7'b0, fe}, 8'h00);
    checkOutput({tag, "_bi"}, {7'b0, bi}, 8'h00);
    checkOutput({tag, "_oe"}, {7'b0, oe}, 8'h00);
  endtask

  // A character is newly presented when valid rises or is reloaded in the
  // same edge that consumed the previous one.
  always @(negedge clk) begin
    if (rst) begin
      validPrev    = 1'b0;
      consumedPrev = 1'b0;
    end else begin
      if (rx_valid && (!validPrev || consumedPrev)) begin
        if (sbQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_char: got 0x%0h, want none", rx_data);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("sb_data", rx_data, e.data);
          checkOutput("sb_pe", {7'b0, pe}, {7'b0, e.pe});
          checkOutput("sb_fe", {7'b0, fe}, {7'b0, e.fe});
          checkOutput("sb_bi", {7'b0, bi}, {7'b0, e.bi});
        end
      end
      validPrev    = rx_valid;
      consumedPrev = rx_valid && rx_ready;
    end
  end

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    wls = 2'b11;
    pen = 1'b0;
    eps = 1'b0;
    sticky_parity = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);

    pushExp(8'hA5, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hA5, 8, 1'b0, 1'b0, -1, 1'b0, 1'b1);
    checkOutput("a5_oe", {7'b0, oe}, 8'h00);

    // 7E1: 0x41 has even popcount, so the expected parity bit is 0.
    wls = 2'b10;
    pen = 1'b1;
    eps = 1'b1;
    pushExp(8'h41, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h41, 7, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    pushExp(8'h41, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h41, 7, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    eps = 1'b0;
    sticky_parity = 1'b1;
    pushExp(8'h41, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h41, 7, 1'b1, 1'b0, -1, 1'b0, 1'b0);

    wls = 2'b11;
    pen = 1'b0;
    sticky_parity = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    pushExp(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8, 1'b0, 1'b0, 3, 1'b0, 1'b0);

    pushExp(8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 480; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0);
    pushExp(8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h55, 8, 1'b0, 1'b0, -1, 1'b0, 1'b1);

    rx_ready = 1'b0;
    pushExp(8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h11, 8, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    applyStimulus(8'h22, 8, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    checkOutput("ovr_valid", {7'b0, rx_valid}, 8'h01);
    checkOutput("ovr_data", rx_data, 8'h11);
    checkOutput("ovr_oe", {7'b0, oe}, 8'h01);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    checkOutput("pop_valid", {7'b0, rx_valid}, 8'h00);
    checkOutput("pop_oe", {7'b0, oe}, 8'h00);
    checkOutput("pop_data", rx_data, 8'h11);

    pushExp(8'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h33, 8, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    pushExp(8'h44, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h44, 8, 1'b0, 1'b0, -1, 1'b1, 1'b0);
    checkOutput("same_valid", {7'b0, rx_valid}, 8'h01);
    checkOutput("same_data", rx_data, 8'h44);
    checkOutput("same_oe", {7'b0, oe}, 8'h00);

    // Abort 0x3C after three data bits with a mid-frame reset.
    sendBit(1'b0, -1);
    sendBit(1'b0, -1);
    sendBit(1'b0, -1);
    sendBit(1'b1, -1);
    rst = 1'b1;
    #2;
    checkAllZero("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    rx_ready = 1'b1;
    pushExp(8'h3C, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h3C, 8, 1'b0, 1'b0, -1, 1'b0, 1'b0);

    for (int i = 0; i < 200 && sbQ.size() != 0; i++) @(posedge clk);
    checkOutput("sb_drain", 8'(sbQ.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
